// File: rtl/lcd_pkg.sv
// Shared constants and types for the paged LCD text renderer.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_SETADDR = 8'h80;

    // DDRAM start address of each display line (HD44780-style layout)
    localparam logic [7:0] LCD_LINE_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    localparam logic LCD_RS_INSTR = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETADDR,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } lcd_state_e;

endpackage

// File: rtl/lcd_nav_ctrl.sv
// Page navigation: up/down wrap counter plus the sticky redraw-pending flag.
module lcd_nav_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_PAGES = 4,
    parameter int unsigned PW        = $clog2(NUM_PAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_redraw,
    input  logic          pending_clr,
    output logic [PW-1:0] page,
    output logic          pending
);

    localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);

    logic [PW-1:0] page_q, page_d;
    logic          pending_q, pending_d;

    // A new event in the same cycle as the clear wins, so it is never lost
    always_comb begin
        page_d    = page_q;
        pending_d = pending_q & ~pending_clr;
        if (btn_up && !btn_down) begin
            page_d    = (page_q == '0) ? LAST_PAGE : page_q - 1'b1;
            pending_d = 1'b1;
        end else if (btn_down && !btn_up) begin
            page_d    = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
            pending_d = 1'b1;
        end
        if (btn_redraw) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            page_q    <= page_d;
            pending_q <= pending_d;
        end
    end

    assign page    = page_q;
    assign pending = pending_q;

endmodule

// File: rtl/lcd_page_seq.sv
// Draws one ROM-backed text page onto a character LCD over a valid/ready
// command stream: clear, then per line a set-address followed by its characters.
module lcd_page_seq
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_PAGES = 4,
    parameter int unsigned LINES     = 2,
    parameter int unsigned COLS      = 16,
    parameter int unsigned AW        = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_redraw,
    output logic [AW-1:0]                rom_addr,
    output logic                         rom_en,
    input  logic [7:0]                   rom_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_rs,
    output logic [7:0]                   cmd_byte,
    output logic [$clog2(NUM_PAGES)-1:0] page,
    output logic                         busy,
    output logic                         draw_done
);

    localparam int unsigned PW = $clog2(NUM_PAGES);
    localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [AW-1:0] PAGE_STRIDE = AW'(LINES * COLS);
    localparam logic [AW-1:0] LINE_STRIDE = AW'(COLS);
    localparam logic [LW-1:0] LAST_LINE   = LW'(LINES - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);

    if (NUM_PAGES < 2) begin : g_chk_pages
        $error("lcd_page_seq: NUM_PAGES must be at least 2");
    end
    if (LINES < 1 || LINES > 4) begin : g_chk_lines
        $error("lcd_page_seq: LINES must be in 1..4");
    end
    if (COLS < 1 || COLS > 20) begin : g_chk_cols
        $error("lcd_page_seq: COLS must be in 1..20");
    end
    if ((NUM_PAGES * LINES * COLS) > (32'd1 << AW)) begin : g_chk_aw
        $error("lcd_page_seq: AW too small for NUM_PAGES*LINES*COLS");
    end

    function automatic logic [AW-1:0] char_addr(input logic [PW-1:0] pg,
                                                input logic [LW-1:0] ln,
                                                input logic [CW-1:0] cl);
        return AW'(pg) * PAGE_STRIDE + AW'(ln) * LINE_STRIDE + AW'(cl);
    endfunction

    function automatic logic [7:0] setaddr_byte(input logic [LW-1:0] ln);
        return LCD_CMD_SETADDR | LCD_LINE_BASE[2'(ln)];
    endfunction

    lcd_state_e    state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [CW-1:0] col_q, col_d;
    logic          init_pending_q, init_pending_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_rs_q, cmd_rs_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          rom_en_q, rom_en_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          busy_q, busy_d;
    logic          draw_done_q, draw_done_d;
    logic          pending;
    logic          pending_clr;
    logic          xfer;

    lcd_nav_ctrl #(
        .NUM_PAGES (NUM_PAGES),
        .PW        (PW)
    ) u_nav (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_redraw  (btn_redraw),
        .pending_clr (pending_clr),
        .page        (page),
        .pending     (pending)
    );

    assign xfer = cmd_valid_q && cmd_ready;

    // Outputs are computed for the state being entered, so they are all registered
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        col_d          = col_q;
        init_pending_d = init_pending_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_rs_d       = cmd_rs_q;
        cmd_byte_d     = cmd_byte_q;
        rom_en_d       = 1'b0;
        rom_addr_d     = rom_addr_q;
        busy_d         = busy_q;
        draw_done_d    = 1'b0;
        pending_clr    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (init_pending_q || pending) begin
                    state_d        = ST_CLEAR;
                    init_pending_d = 1'b0;
                    pending_clr    = 1'b1;
                    busy_d         = 1'b1;
                    cmd_valid_d    = 1'b1;
                    cmd_rs_d       = LCD_RS_INSTR;
                    cmd_byte_d     = LCD_CMD_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (xfer) begin
                    state_d    = ST_SETADDR;
                    line_d     = '0;
                    cmd_byte_d = setaddr_byte('0);
                end
            end
            ST_SETADDR: begin
                if (xfer) begin
                    state_d     = ST_FETCH;
                    col_d       = '0;
                    cmd_valid_d = 1'b0;
                    rom_en_d    = 1'b1;
                    rom_addr_d  = char_addr(page, line_q, '0);
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d     = ST_SEND;
                cmd_valid_d = 1'b1;
                cmd_rs_d    = LCD_RS_DATA;
                cmd_byte_d  = rom_data;
            end
            ST_SEND: begin
                if (xfer) begin
                    if (col_q != LAST_COL) begin
                        state_d     = ST_FETCH;
                        col_d       = col_q + 1'b1;
                        cmd_valid_d = 1'b0;
                        rom_en_d    = 1'b1;
                        rom_addr_d  = char_addr(page, line_q, col_q + 1'b1);
                    end else if (line_q != LAST_LINE) begin
                        state_d    = ST_SETADDR;
                        line_d     = line_q + 1'b1;
                        cmd_rs_d   = LCD_RS_INSTR;
                        cmd_byte_d = setaddr_byte(line_q + 1'b1);
                    end else begin
                        state_d     = ST_DONE;
                        cmd_valid_d = 1'b0;
                        draw_done_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            line_q         <= '0;
            col_q          <= '0;
            init_pending_q <= 1'b1;
            cmd_valid_q    <= 1'b0;
            cmd_rs_q       <= 1'b0;
            cmd_byte_q     <= '0;
            rom_en_q       <= 1'b0;
            rom_addr_q     <= '0;
            busy_q         <= 1'b0;
            draw_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_q         <= line_d;
            col_q          <= col_d;
            init_pending_q <= init_pending_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_rs_q       <= cmd_rs_d;
            cmd_byte_q     <= cmd_byte_d;
            rom_en_q       <= rom_en_d;
            rom_addr_q     <= rom_addr_d;
            busy_q         <= busy_d;
            draw_done_q    <= draw_done_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_rs    = cmd_rs_q;
    assign cmd_byte  = cmd_byte_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;
    assign draw_done = draw_done_q;

endmodule

// File: tb/tb_lcd_page_seq.sv
// Directed and randomized bench for lcd_page_seq against a page-level stream model.
module tb_lcd_page_seq;

    localparam int unsigned NP       = 4;
    localparam int unsigned NL       = 2;
    localparam int unsigned NC       = 16;
    localparam int unsigned AWID     = 7;
    localparam int unsigned CHARS    = NL * NC;
    localparam int unsigned DRAW_LEN = 1 + NL + NL * NC;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            btn_up = 1'b0;
    logic            btn_down = 1'b0;
    logic            btn_redraw = 1'b0;
    logic            cmd_ready = 1'b1;
    logic [AWID-1:0] rom_addr;
    logic            rom_en;
    logic [7:0]      rom_data = '0;
    logic            cmd_valid;
    logic            cmd_rs;
    logic [7:0]      cmd_byte;
    logic [1:0]      page;
    logic            busy;
    logic            draw_done;

    lcd_page_seq #(
        .NUM_PAGES (NP),
        .LINES     (NL),
        .COLS      (NC),
        .AW        (AWID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_redraw (btn_redraw),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rs     (cmd_rs),
        .cmd_byte   (cmd_byte),
        .page       (page),
        .busy       (busy),
        .draw_done  (draw_done)
    );

    always #5 clk = ~clk;

    // Character ROM with one cycle of read latency
    logic [7:0] rom_mem [1 << AWID];
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    // Transfer log, draw_done counter and hold-while-stalled watcher
    logic [8:0]  obs[$];
    logic [8:0]  exp_q[$];
    int unsigned done_cnt = 0;
    int unsigned hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_off = '0;

    always @(negedge clk) begin
        if (prev_stall && !rst && !(cmd_valid && {cmd_rs, cmd_byte} == prev_off)) hold_err++;
        prev_stall = !rst && cmd_valid && !cmd_ready;
        prev_off   = {cmd_rs, cmd_byte};
        if (!rst && cmd_valid && cmd_ready) obs.push_back({cmd_rs, cmd_byte});
        if (!rst && draw_done) done_cnt++;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        rnd_ready = 1'b0;
    int unsigned pm = 0;
    int unsigned base_cnt;
    int unsigned k;
    int unsigned op;
    int          line_base [4] = '{'h00, 'h40, 'h14, 'h54};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) cmd_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic pulse(input int unsigned which);
        if (which == 0) btn_up = 1'b1;
        else if (which == 1) btn_down = 1'b1;
        else btn_redraw = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_redraw = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned target, input int unsigned budget);
        int unsigned w = 0;
        while (done_cnt < target && w < budget) begin
            cyc(1);
            w++;
        end
        check({tag, " timeout"}, 32'(done_cnt >= target), 32'd1);
    endtask

    // Expected stream for a whole page: clear, then per line set-address and its text
    function automatic void build_exp(input int unsigned p);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h01});
        for (int l = 0; l < int'(NL); l++) begin
            exp_q.push_back({1'b0, 8'(8'h80 + line_base[l])});
            for (int c = 0; c < int'(NC); c++)
                exp_q.push_back({1'b1, rom_mem[p * CHARS + l * NC + c]});
        end
    endfunction

    task automatic check_draw(input string tag, input int unsigned start, input int unsigned p);
        build_exp(p);
        check({tag, " length"}, 32'(obs.size()), 32'(start + DRAW_LEN));
        for (int unsigned i = 0; i < DRAW_LEN; i++) begin
            if (start + i < obs.size())
                check($sformatf("%s[%0d]", tag, i), 32'(obs[start + i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        foreach (rom_mem[i]) rom_mem[i] = 8'($urandom);

        // Reset values
        cyc(3);
        check("rst cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst cmd_rs", 32'(cmd_rs), 32'd0);
        check("rst cmd_byte", 32'(cmd_byte), 32'd0);
        check("rst rom_en", 32'(rom_en), 32'd0);
        check("rst rom_addr", 32'(rom_addr), 32'd0);
        check("rst page", 32'(page), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst draw_done", 32'(draw_done), 32'd0);

        // Automatic page-0 draw after reset: 2 commands + 16x3 per line + set-address
        obs.delete();
        rst = 1'b0;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!draw_done && k < 300);
        check("first draw latency", k, 32'd100);
        cyc(2);
        check("first draw_done count", done_cnt, 32'd1);
        check("first busy after", 32'(busy), 32'd0);
        check_draw("page0 draw", 0, 0);

        // Up from page 0 wraps to the last page, down returns
        cyc(3);
        obs.delete();
        base_cnt = done_cnt;
        pulse(0);
        pm = (pm + NP - 1) % NP;
        check("up page", 32'(page), pm);
        wait_done("up draw", base_cnt + 1, 400);
        cyc(3);
        check_draw("up draw", 0, pm);

        obs.delete();
        base_cnt = done_cnt;
        pulse(1);
        pm = (pm + 1) % NP;
        check("down page", 32'(page), pm);
        wait_done("down draw", base_cnt + 1, 400);
        cyc(3);
        check_draw("down draw", 0, pm);

        // Stall for 5 cycles while the 4th character is offered
        obs.delete();
        base_cnt = done_cnt;
        pulse(2);
        k = 0;
        while (!(obs.size() == 5 && cmd_valid && cmd_rs) && k < 200) begin
            cyc(1);
            k++;
        end
        check("stall point found", 32'(k < 200), 32'd1);
        cmd_ready = 1'b0;
        cyc(5);
        check("stall valid held", 32'(cmd_valid), 32'd1);
        check("stall byte held", 32'(cmd_byte), 32'(rom_mem[pm * CHARS + 3]));
        cmd_ready = 1'b1;
        wait_done("stall draw", base_cnt + 1, 400);
        cyc(3);
        check_draw("stall draw", 0, pm);

        // Random backpressure across a whole draw
        obs.delete();
        base_cnt = done_cnt;
        pulse(2);
        rnd_ready = 1'b1;
        wait_done("rnd ready draw", base_cnt + 1, 2000);
        rnd_ready = 1'b0;
        cmd_ready = 1'b1;
        cyc(3);
        check_draw("rnd ready draw", 0, pm);
        check("hold violations", hold_err, 32'd0);

        // Down at the 10th character: a second full draw of the new page follows
        obs.delete();
        base_cnt = done_cnt;
        pulse(2);
        k = 0;
        while (obs.size() != 11 && k < 200) begin
            cyc(1);
            k++;
        end
        pulse(1);
        pm = (pm + 1) % NP;
        check("mid-draw nav page", 32'(page), pm);
        wait_done("nav redraw", base_cnt + 2, 800);
        cyc(30);
        check("nav draw_done count", done_cnt - base_cnt, 32'd2);
        check_draw("nav second draw", DRAW_LEN, pm);

        // Up and down together while idle: nothing happens
        obs.delete();
        base_cnt = done_cnt;
        btn_up = 1'b1;
        btn_down = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        btn_down = 1'b0;
        cyc(20);
        check("both btn transfers", 32'(obs.size()), 32'd0);
        check("both btn page", 32'(page), pm);
        check("both btn draws", done_cnt - base_cnt, 32'd0);

        // Three redraws during one draw collapse into one extra draw
        obs.delete();
        base_cnt = done_cnt;
        pulse(2);
        cyc(5);
        pulse(2);
        cyc(20);
        pulse(2);
        cyc(20);
        pulse(2);
        wait_done("collapse", base_cnt + 2, 800);
        cyc(150);
        check("collapse draw count", done_cnt - base_cnt, 32'd2);
        check_draw("collapse second draw", DRAW_LEN, pm);

        // Reset in the middle of line 1
        obs.delete();
        pulse(2);
        k = 0;
        while (obs.size() < 25 && k < 300) begin
            cyc(1);
            k++;
        end
        check("mid line1 reached", 32'(k < 300), 32'd1);
        rst = 1'b1;
        cyc(1);
        pm = 0;
        check("abort cmd_valid", 32'(cmd_valid), 32'd0);
        check("abort page", 32'(page), pm);
        check("abort busy", 32'(busy), 32'd0);
        cyc(2);
        obs.delete();
        base_cnt = done_cnt;
        rst = 1'b0;
        wait_done("post-reset draw", base_cnt + 1, 400);
        cyc(3);
        check_draw("post-reset draw", 0, pm);

        // Random navigation with random backpressure
        for (int r = 0; r < 6; r++) begin
            cyc($urandom_range(1, 8));
            obs.delete();
            base_cnt = done_cnt;
            op = $urandom_range(0, 2);
            pulse(op);
            if (op == 0) pm = (pm + NP - 1) % NP;
            else if (op == 1) pm = (pm + 1) % NP;
            check($sformatf("rnd%0d page", r), 32'(page), pm);
            rnd_ready = 1'b1;
            wait_done($sformatf("rnd%0d draw", r), base_cnt + 1, 2000);
            rnd_ready = 1'b0;
            cmd_ready = 1'b1;
            cyc(3);
            check_draw($sformatf("rnd%0d draw", r), 0, pm);
        end
        check("final hold violations", hold_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
